// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_exec_ctrl                                                     |
// | Brief  : Four-state execute controller that sequences an external 16-bit   |
// |          ALU. It owns a 16x16 register file and a {C,L,F,Z,N} PSR.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module alu_exec_ctrl #(
  parameter int                NREG_LOG2   = 4,
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_instr,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [3:0]           alu_op,
  output logic [3:0]           alu_ext,
  output logic                 alu_cin,
  input  logic [DATA_W-1:0]    alu_s,
  input  logic [4:0]           alu_flags,
  output logic                 done,
  output logic [4:0]           psr,
  input  logic [NREG_LOG2-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  localparam int       c_NREG     = 1 << NREG_LOG2;
  localparam logic [3:0] c_OP_REG  = 4'b0000;
  localparam logic [3:0] c_OP_RCMPU = 4'b1010;
  localparam logic [3:0] c_OP_R8    = 4'b1000;
  localparam logic [3:0] c_OP_ADDUI = 4'b0110;
  localparam logic [3:0] c_OP_CMPI  = 4'b1011;
  localparam logic [3:0] c_OP_MOVI  = 4'b1101;
  localparam logic [3:0] c_EXT_MOV  = 4'b1101;
  localparam logic [3:0] c_EXT_CMP  = 4'b1011;
  localparam logic [3:0] c_EXT_CMPU = 4'b0010;
  localparam logic [3:0] c_EXT_R8   = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t              r_state;
  logic [15:0]         r_ir;
  logic                r_in_ready;
  logic                r_done;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [3:0]          r_alu_op;
  logic [3:0]          r_alu_ext;
  logic [DATA_W-1:0]   r_result;
  logic [4:0]          r_flags;
  logic [4:0]          r_psr;
  logic [DATA_W-1:0]   r_regs [0:c_NREG-1];

  logic [3:0]          w_op;
  logic [3:0]          w_rd;
  logic [3:0]          w_ext;
  logic [3:0]          w_rs;
  logic                w_reg_form;
  logic                w_mov;
  logic                w_nop;
  logic                w_no_wb;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_src;

  assign w_op  = r_ir[15:12];
  assign w_rd  = r_ir[11:8];
  assign w_ext = r_ir[7:4];
  assign w_rs  = r_ir[3:0];

  assign w_reg_form = (w_op == c_OP_REG) || (w_op == c_OP_RCMPU) ||
                      ((w_op == c_OP_R8) && (w_ext == c_EXT_R8));

  // ADDUI is the only immediate op that zero-extends its 8-bit immediate
  assign w_imm = (w_op == c_OP_ADDUI) ? {{(DATA_W-8){1'b0}}, r_ir[7:0]}
                                      : {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
  assign w_src = w_reg_form ? r_regs[w_rs] : w_imm;

  assign w_mov   = ((w_op == c_OP_REG) && (w_ext == c_EXT_MOV)) || (w_op == c_OP_MOVI);
  assign w_nop   = (r_ir[15:4] == 12'h000);
  assign w_no_wb = w_nop ||
                   ((w_op == c_OP_REG) && (w_ext == c_EXT_CMP)) ||
                   (w_op == c_OP_CMPI) ||
                   ((w_op == c_OP_RCMPU) && (w_ext == c_EXT_CMPU));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_in_ready <= 1'b1;
      r_done     <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_alu_ext  <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_psr      <= '0;
      for (int i = 0; i < c_NREG; i++) begin
        r_regs[i] <= REG_RST_VAL;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_ir       <= in_instr;
            r_in_ready <= 1'b0;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_alu_a   <= w_mov ? w_src : r_regs[w_rd];
          r_alu_b   <= w_mov ? '0    : w_src;
          r_alu_op  <= w_op;
          r_alu_ext <= w_ext;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= alu_s;
          r_flags  <= alu_flags;
          r_done   <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          if (!w_no_wb) begin
            r_regs[w_rd] <= r_result;
          end
          if (!w_nop) begin
            r_psr <= r_flags;
          end
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign done     = r_done;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign alu_ext  = r_alu_ext;
  assign alu_cin  = r_psr[4];
  assign psr      = r_psr;
  assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_alu_exec_ctrl                                                  |
// | Brief  : Scoreboard bench for alu_exec_ctrl with a behavioural ALU.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_alu_exec_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [3:0]  alu_ext;
  logic        alu_cin;
  logic [15:0] alu_s;
  logic [4:0]  alu_flags;
  logic        done;
  logic [4:0]  psr;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_exec_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_ext   (alu_ext),
    .alu_cin   (alu_cin),
    .alu_s     (alu_s),
    .alu_flags (alu_flags),
    .done      (done),
    .psr       (psr),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {flags[4:0], s[15:0]}; unknown ops give 0/0
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [3:0] ext,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
    logic [16:0] sum;
    logic [15:0] s;
    logic [4:0]  f;
    int          kind;
    s    = '0;
    f    = '0;
    kind = 0;
    case (op)
      4'b0000: begin
        case (ext)
          4'b0101: kind = 1;
          4'b0110: kind = 2;
          4'b0111: kind = 3;
          4'b1011: kind = 4;
          4'b1101: kind = 5;
          default: kind = 0;
        endcase
      end
      4'b0101: kind = 1;
      4'b0110: kind = 2;
      4'b0111: kind = 3;
      4'b1011: kind = 4;
      4'b1101: kind = 5;
      4'b1010: kind = (ext == 4'b0010) ? 4 : 0;
      default: kind = 0;
    endcase
    sum = {1'b0, a} + {1'b0, b} + {16'b0, ((kind == 3) ? cin : 1'b0)};
    case (kind)
      1, 2, 3: begin
        s = sum[15:0];
        f = {sum[16], 1'b0, ((a[15] == b[15]) && (s[15] != a[15])), 2'b00};
      end
      4: f = {1'b0, (a > b), 1'b0, (a == b), ($signed(a) > $signed(b))};
      5: s = a;
      default: s = '0;
    endcase
    return {f, s};
  endfunction

  always_comb begin
    {alu_flags, alu_s} = alu_fn(alu_op, alu_ext, alu_a, alu_b, alu_cin);
  end

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [4:0]  psr;
    int          acc;
  } exp_t;

  int          n_checks;
  int          n_pass;
  logic [15:0] m_reg [0:15];
  logic [4:0]  m_psr;
  logic [15:0] prog [$];
  exp_t        sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_psr = 5'b0;
    sb.delete();
  endtask

  // Reference execution of one instruction against the model state
  task automatic model_exec(input logic [15:0] ins, output exp_t e);
    logic [3:0]  op, rd, ext, rs;
    logic [15:0] imm, src, a, b;
    logic [20:0] r;
    logic        regf, mov, nop, nowb;
    op   = ins[15:12];
    rd   = ins[11:8];
    ext  = ins[7:4];
    rs   = ins[3:0];
    regf = (op == 4'b0000) || (op == 4'b1010) || (op == 4'b1000 && ext == 4'b0100);
    imm  = (op == 4'b0110) ? {8'h00, ins[7:0]} : {{8{ins[7]}}, ins[7:0]};
    src  = regf ? m_reg[rs] : imm;
    mov  = (op == 4'b0000 && ext == 4'b1101) || (op == 4'b1101);
    a    = mov ? src : m_reg[rd];
    b    = mov ? 16'h0000 : src;
    r    = alu_fn(op, ext, a, b, m_psr[4]);
    nop  = (ins[15:4] == 12'h000);
    nowb = nop || (op == 4'b0000 && ext == 4'b1011) || (op == 4'b1011) ||
           (op == 4'b1010 && ext == 4'b0010);
    if (!nowb) m_reg[rd] = r[15:0];
    if (!nop)  m_psr = r[20:16];
    e.rd  = rd;
    e.val = m_reg[rd];
    e.psr = m_psr;
    e.acc = 0;
  endtask

  task automatic run_prog(input int budget);
    int   idx;
    int   since;
    logic wb_pend;
    exp_t cur;
    exp_t e;
    idx     = 0;
    since   = 0;
    wb_pend = 1'b0;
    cur     = '{rd: 4'h0, val: 16'h0, psr: 5'h0, acc: 0};
    for (int cyc = 0; cyc < budget && (idx < prog.size() || sb.size() > 0 || wb_pend); cyc++) begin
      @(negedge clk);
      in_valid = (idx < prog.size());
      in_instr = in_valid ? prog[idx] : 16'h0000;
      if (wb_pend) dbg_addr = cur.rd;
      #1;
      if (wb_pend) begin
        chk("wb_reg", dbg_data, cur.val);
        chk("wb_psr", psr, cur.psr);
        wb_pend = 1'b0;
      end
      if (since > 0) begin
        chk("busy_ready", in_ready, 0);
        since = (since == 3) ? 0 : since + 1;
      end
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", done, 0);
        else begin
          cur = sb.pop_front();
          chk("latency", cyc - cur.acc, 3);
          wb_pend = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        model_exec(prog[idx], e);
        e.acc = cyc;
        sb.push_back(e);
        idx++;
        since = 1;
      end
    end
    in_valid = 1'b0;
    chk("accept_count", idx, prog.size());
    chk("pending", sb.size(), 0);
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  logic [15:0] d;
  logic        saw_done;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    dbg_addr = 4'h0;
    model_reset();

    // T1: asynchronous reset before the first clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_psr", psr, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk("rst_reg", dbg_data, 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // T2: MOVI with positive and negative immediates, then an undefined opcode
    prog = '{16'hD37F, 16'hD480};
    run_prog(60);
    rd(4'd3, d); chk("t2_r3", d, 16'h007F);
    rd(4'd4, d); chk("t2_r4", d, 16'hFF80);
    prog = '{16'hF312};
    run_prog(30);
    rd(4'd3, d); chk("undef_r3", d, 16'h0000);

    // T3: ADDU carry out, then ADDC consumes it
    prog = '{16'hD5FF, 16'hD601, 16'h0566};
    run_prog(60);
    rd(4'd5, d); chk("t3_r5", d, 16'h0000);
    chk("t3_c", psr[4], 1);
    prog = '{16'h0778};
    run_prog(30);
    rd(4'd7, d); chk("t3_r7", d, 16'h0001);

    // T4: CMP/CMPU do not write, NOP keeps the PSR
    prog = '{16'hD105, 16'hD203, 16'h01B2, 16'h0000, 16'hA122};
    run_prog(80);
    rd(4'd1, d); chk("t4_r1", d, 16'h0005);
    chk("t4_psr", psr, 5'b01001);

    // T5: in_valid held high across three dependent instructions
    prog = '{16'hD905, 16'h6980, 16'h0AD9, 16'h52FF};
    run_prog(80);
    rd(4'd9,  d); chk("t5_r9", d, 16'h0085);
    rd(4'd10, d); chk("t5_r10", d, 16'h0085);
    rd(4'd2,  d); chk("t5_r2", d, 16'h0002);

    // T6: reset during EXEC abandons the instruction
    prog = '{16'hD209};
    run_prog(30);
    rd(4'd2, d); chk("t6_r2_pre", d, 16'h0009);
    @(negedge clk);
    in_instr = 16'h5201;
    in_valid = 1'b1;
    #1 chk("t6_accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("t6_exec_busy", in_ready, 0);
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    chk("t6_no_done", saw_done, 0);
    chk("t6_ready", in_ready, 1);
    chk("t6_psr", psr, 0);
    rd(4'd2, d); chk("t6_r2", d, 16'h0000);
    prog = '{16'h0000, 16'hD2FE};
    run_prog(40);
    rd(4'd2, d); chk("t6_r2_post", d, 16'hFFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
